fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- IF stage of the pipelined MIPS core; the producer side of the decode interface.
- Issues in-order instruction-memory requests through a valid/ready handshake and buffers returned words in a small FIFO.
- Presents one registered instruction per cycle to decode on FetchData_IF, holds it while AnyStall is high, and redirects on a decode-stage jump or an execute-stage branch redirect.
- Stale responses from before a redirect are dropped.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- FIFO_DEPTH, 2, entries in the response FIFO; power of two, >= 2; also the credit limit on outstanding requests.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- AnyStall  in  1  decode stall; hold the IF/ID output register.
- Jump_ID  in  1  decode saw J/JAL in the current FetchData_IF.
- JumpTgt_ID  in  26  instr_index field of that jump.
- Redirect_EX  in  1  taken-branch redirect from execute.
- RedirectPc_EX  in  32  branch target address.
- IReq_valid  out  1  instruction-memory request valid.
- IReq_addr  out  32  word-aligned request address.
- IReq_ready  in  1  memory accepts the request this cycle.
- IResp_valid  in  1  response data valid; responses return in request order.
- IResp_data  in  32  instruction word.
- FetchData_IF  out  32  instruction to decode; NOP (32'h0) when FetchValid_IF=0.
- FetchValid_IF  out  1  FetchData_IF holds a real instruction.
- PcPlus4_IF  out  32  PC+4 of the instruction in FetchData_IF.

Behaviour:
- Reset: fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; FetchData_IF=0; FetchValid_IF=0; PcPlus4_IF=0; IReq_valid=0 during reset, 1 from the first cycle after.
- Request issue: IReq_valid=1 when outstanding+fifo_count < FIFO_DEPTH. A response therefore always has a FIFO slot; IResp_ready is not needed.
- IReq_addr=fetch_pc. A handshake (valid and ready) means outstanding+1 and fetch_pc+=4. IReq_addr changes without a handshake only in a redirect cycle.
- Response with drop_cnt>0: word discarded; drop_cnt-1; outstanding-1.
- Response with drop_cnt=0: push {addr+4, data} into the FIFO; outstanding-1. The entry PC+4 comes from an in-order address shadow, resp_pc, advanced by 4 per response.
- Output register, when AnyStall=0 and no redirect:
  - FIFO non-empty: pop the head into FetchData_IF/PcPlus4_IF, FetchValid_IF=1.
  - FIFO empty: load a bubble (data 0, valid 0, PcPlus4_IF unchanged).
- A same-cycle push into an empty FIFO is not bypassed; 1-cycle FIFO latency is fixed.
- AnyStall=1: output register holds; FIFO and request logic continue within credit.
- Jump redirect: when Jump_ID=1, FetchValid_IF=1 and AnyStall=0:
  - target = {PcPlus4_IF[31:28], JumpTgt_ID, 2'b00}.
  - No delay slot; sequential instructions are squashed.
- Redirect_EX=1 applies regardless of AnyStall, with target = RedirectPc_EX.
- Priority: reset > Redirect_EX > Jump_ID.
- Any redirect, next cycle:
  - fetch_pc = target; resp_pc = target.
  - FIFO flushed.
  - drop_cnt = outstanding, adjusted for that cycle's response (-1) and handshake (+1 counts as stale).
  - Output register = bubble; FetchValid_IF=0.
- A redirect arriving while drop_cnt>0 recomputes drop_cnt as above; it does not accumulate.
- Wrap-around: fetch_pc wraps modulo 2^32 with no error.
- Counters and drop_cnt are $clog2(FIFO_DEPTH)+1 bits wide.
- Assertions: push when full, response with outstanding=0, IReq_addr[1:0]!=0.

Decomposition:
- Shared package (core_pkg): NOP_INSTR=32'h0, RESET_PC default, and jump-target concatenation as a function, shared with the branch unit.
- One sub-module, fetch_fifo: synchronous FIFO, parameter WIDTH=64, DEPTH=FIFO_DEPTH.
  - Ports: push, pop, flush, din, dout, count, empty, full.
  - flush takes priority over push/pop; reset clears it.

Test Plan:
- Reset, IReq_ready=1, 1-cycle memory returning addr-as-data -> requests 0x0,0x4,0x8; FetchData_IF 0x0,0x4,0x8 back-to-back with FetchValid_IF=1 from cycle 3; PcPlus4_IF 0x4,0x8,0xC.
- AnyStall=1 for 3 cycles while 0x4 is presented -> FetchData_IF held at 0x4; at most FIFO_DEPTH requests outstanding plus buffered; 0x8 presented the first cycle after stall release, no instruction lost.
- Jump_ID=1, JumpTgt_ID=26'h40 at PcPlus4_IF=0x10000008 -> next IReq_addr=0x10000100; one bubble; responses for 0x8/0xC dropped; first valid output is the word from 0x10000100.
- Redirect_EX=1 with RedirectPc_EX=0x200 in the same cycle as Jump_ID=1, with AnyStall=1 -> target 0x200 wins; jump ignored.
- IReq_ready=0 for 5 cycles -> IReq_addr stable; IReq_valid held 1; FetchValid_IF=0 once the FIFO drains.
- Redirect issued while 2 requests are outstanding and a response arrives that cycle -> drop_cnt=1; exactly one further response discarded; reset mid-drop clears all state and restarts fetch at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: NOP encoding, reset PC default, fetch FIFO entry
// layout and the J-type target helper used by fetch and the branch unit.
package core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_JUMP,
    REDIR_EX
  } redir_src_t;

  // J/JAL target: upper PC nibble of the delay-free successor, instr_index, word offset.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [25:0] instr_index);
    return {pc_plus4[31:28], instr_index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO for fetched {pc+4, instr} entries.
// flush wins over push/pop; no read bypass, so a pushed word is visible next cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// IF stage: credit-limited in-order I-memory requests, response FIFO, and the
// registered IF/ID output with jump / execute-redirect handling.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        AnyStall,
  input  logic        Jump_ID,
  input  logic [25:0] JumpTgt_ID,
  input  logic        Redirect_EX,
  input  logic [31:0] RedirectPc_EX,
  output logic        IReq_valid,
  output logic [31:0] IReq_addr,
  input  logic        IReq_ready,
  input  logic        IResp_valid,
  input  logic [31:0] IResp_data,
  output logic [31:0] FetchData_IF,
  output logic        FetchValid_IF,
  output logic [31:0] PcPlus4_IF
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;
  logic [31:0]   r_data;
  logic [31:0]   r_pc4;
  logic          r_valid;

  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  redir_src_t    w_redir_src;
  logic [31:0]   w_redir_tgt;
  logic          w_redirect;
  logic          w_hs;
  logic          w_keep;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_inflight;
  logic [CW-1:0] w_outstanding_nxt;

  // Credit covers both in-flight requests and buffered words, so every response has a slot.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign IReq_valid = ~reset & (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign IReq_addr  = r_fetch_pc;
  assign w_hs       = IReq_valid & IReq_ready;

  assign w_keep            = IResp_valid & (r_drop_cnt == '0);
  assign w_outstanding_nxt = r_outstanding + CW'(w_hs) - CW'(IResp_valid);

  always_comb begin
    w_redir_src = REDIR_NONE;
    w_redir_tgt = r_fetch_pc;
    if (Redirect_EX) begin
      w_redir_src = REDIR_EX;
      w_redir_tgt = RedirectPc_EX;
    end else if (Jump_ID && r_valid && !AnyStall) begin
      w_redir_src = REDIR_JUMP;
      w_redir_tgt = jump_target(r_pc4, JumpTgt_ID);
    end
  end

  assign w_redirect = (w_redir_src != REDIR_NONE);
  assign w_push     = w_keep & ~w_redirect;
  assign w_pop      = ~AnyStall & ~w_redirect & ~w_fifo_empty;

  assign w_push_entry.pc_plus4 = r_resp_pc + 32'd4;
  assign w_push_entry.instr    = IResp_data;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redirect),
    .din   (w_push_entry),
    .dout  (w_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_data        <= NOP_INSTR;
      r_valid       <= 1'b0;
      r_pc4         <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (w_redirect) begin
        // Everything still in flight after this edge belongs to the old stream.
        r_fetch_pc <= w_redir_tgt;
        r_resp_pc  <= w_redir_tgt;
        r_drop_cnt <= w_outstanding_nxt;
        r_data     <= NOP_INSTR;
        r_valid    <= 1'b0;
      end else begin
        if (w_hs)   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
        if (IResp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (!AnyStall) begin
          if (!w_fifo_empty) begin
            r_data  <= w_head.instr;
            r_pc4   <= w_head.pc_plus4;
            r_valid <= 1'b1;
          end else begin
            r_data  <= NOP_INSTR;
            r_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign FetchData_IF  = r_data;
  assign FetchValid_IF = r_valid;
  assign PcPlus4_IF    = r_pc4;

  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(w_push && w_fifo_full));
  a_resp_has_req: assert property (@(posedge clk) disable iff (reset)
    IResp_valid |-> (r_outstanding != '0));
  a_addr_aligned: assert property (@(posedge clk)
    IReq_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: expected instruction stream is the
// architectural PC sequence, rebuilt from the redirects the bench itself issues.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          D      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        AnyStall, Jump_ID, Redirect_EX, IReq_ready, IResp_valid;
  logic [25:0] JumpTgt_ID;
  logic [31:0] RedirectPc_EX, IResp_data;
  logic        IReq_valid, FetchValid_IF;
  logic [31:0] IReq_addr, FetchData_IF, PcPlus4_IF;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .AnyStall(AnyStall), .Jump_ID(Jump_ID),
    .JumpTgt_ID(JumpTgt_ID), .Redirect_EX(Redirect_EX), .RedirectPc_EX(RedirectPc_EX),
    .IReq_valid(IReq_valid), .IReq_addr(IReq_addr), .IReq_ready(IReq_ready),
    .IResp_valid(IResp_valid), .IResp_data(IResp_data), .FetchData_IF(FetchData_IF),
    .FetchValid_IF(FetchValid_IF), .PcPlus4_IF(PcPlus4_IF)
  );

  typedef struct { logic [31:0] data; logic [31:0] pc4; } exp_t;
  typedef struct { logic [31:0] addr; int t; } req_t;

  exp_t        exp_q[$];
  req_t        pend[$];
  logic [31:0] next_pc;
  logic [31:0] req_exp;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          since = 0;
  int          first_valid = -1;
  bit          prev_rst = 1'b0;
  bit          fix_rt_en = 1'b0, fix_jt_en = 1'b0, jumped = 1'b0;
  logic [31:0] fix_rt = '0, jump_at = '0;
  logic [25:0] fix_jt = '0;

  // Memory returns the address itself as the instruction word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  function automatic logic [31:0] rand_target();
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF0;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{mem_word(next_pc), next_pc + 32'd4});
      next_pc += 32'd4;
    end
  endtask

  // Monitor / memory bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      pend.delete();
      req_exp     = RST_PC;
      since       = 0;
      first_valid = -1;
      if (prev_rst) begin
        check("rst_valid", 32'(FetchValid_IF), 32'd0);
        check("rst_data",  FetchData_IF, 32'd0);
        check("rst_pc4",   PcPlus4_IF, 32'd0);
        check("rst_req_valid", 32'(IReq_valid), 32'd0);
      end
    end else begin
      if (since == 0) begin
        check("post_rst_req_valid", 32'(IReq_valid), 32'd1);
        check("post_rst_addr", IReq_addr, RST_PC);
      end
      if (first_valid < 0 && FetchValid_IF) first_valid = since;
      since++;
      if (!FetchValid_IF) check("nop_when_invalid", FetchData_IF, 32'd0);
      if (IReq_valid && IReq_ready) begin
        check("credit", 32'(pend.size() < D), 32'd1);
        check("req_addr", IReq_addr, req_exp);
        pend.push_back('{IReq_addr, cyc});
        req_exp += 32'd4;
      end
      if (IResp_valid && pend.size() > 0) void'(pend.pop_front());
      if (Redirect_EX) begin
        req_exp = RedirectPc_EX;
      end else if (FetchValid_IF && !AnyStall) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("instr", FetchData_IF, e.data);
          check("pc_plus4", PcPlus4_IF, e.pc4);
          if (Jump_ID) req_exp = {e.pc4[31:28], JumpTgt_ID, 2'b00};
        end
      end
    end
    prev_rst = reset;
  end

  // One cycle of stimulus; arguments are percentages.
  task automatic step(input int pr, input int ps, input int pst, input int pj, input int prd);
    bit          intend;
    bit          applies;
    logic [31:0] jt;
    @(posedge clk); #1; cyc++;
    IReq_ready = ($urandom_range(99) < pr);
    if (pend.size() > 0 && pend[0].t < cyc && $urandom_range(99) < ps) begin
      IResp_valid = 1'b1;
      IResp_data  = mem_word(pend[0].addr);
    end else begin
      IResp_valid = 1'b0;
      IResp_data  = $urandom;
    end
    AnyStall      = ($urandom_range(99) < pst);
    Redirect_EX   = ($urandom_range(99) < prd);
    RedirectPc_EX = fix_rt_en ? fix_rt : rand_target();
    JumpTgt_ID    = fix_jt_en ? fix_jt : 26'($urandom);
    applies = FetchValid_IF && !AnyStall && !Redirect_EX;
    intend  = applies && exp_q.size() > 0 && (jump_at == '0 || exp_q[0].pc4 == jump_at)
              && ($urandom_range(99) < pj);
    Jump_ID = intend || (!applies && ($urandom_range(99) < pj));
    if (Redirect_EX) begin
      exp_q.delete();
      next_pc = RedirectPc_EX;
    end else if (intend) begin
      jt = {exp_q[0].pc4[31:28], JumpTgt_ID, 2'b00};
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      next_pc = jt;
      jumped  = 1'b1;
    end
    refill();
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1; cyc++;
    reset = 1'b1; IResp_valid = 1'b0; IReq_ready = 1'b0; AnyStall = 1'b0;
    Jump_ID = 1'b0; Redirect_EX = 1'b0;
    exp_q.delete();
    repeat (n - 1) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1; cyc++;
    reset = 1'b0; IReq_ready = 1'b1;
    next_pc = RST_PC;
    refill();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; AnyStall = 1'b0; Jump_ID = 1'b0; JumpTgt_ID = '0; Redirect_EX = 1'b0;
    RedirectPc_EX = '0; IReq_ready = 1'b0; IResp_valid = 1'b0; IResp_data = '0;
    do_reset(3);

    // 1-cycle memory, always ready: first valid instruction three cycles after reset.
    repeat (12) step(100, 100, 0, 0, 0);
    check("first_valid_cycle", 32'(first_valid), 32'd3);

    // Stall hold and release.
    repeat (3) step(100, 100, 100, 0, 0);
    repeat (10) step(100, 100, 0, 0, 0);

    // Jump from the instruction at 0x10000004 to instr_index 0x40.
    fix_rt_en = 1'b1; fix_rt = 32'h1000_0000;
    step(100, 100, 0, 0, 100);
    fix_rt_en = 1'b0;
    jump_at = 32'h1000_0008; fix_jt_en = 1'b1; fix_jt = 26'h40; jumped = 1'b0;
    for (int i = 0; i < 40 && !jumped; i++) step(100, 100, 0, 100, 0);
    check("jump_issued", 32'(jumped), 32'd1);
    jump_at = '0; fix_jt_en = 1'b0;
    step(100, 100, 0, 0, 0);
    check("jump_req_addr", IReq_addr, 32'h1000_0100);
    check("jump_bubble", 32'(FetchValid_IF), 32'd0);
    repeat (15) step(100, 100, 0, 0, 0);

    // Execute redirect beats a same-cycle jump, even under stall.
    fix_rt_en = 1'b1; fix_rt = 32'h0000_0200;
    step(100, 100, 100, 100, 100);
    fix_rt_en = 1'b0;
    step(100, 100, 0, 0, 0);
    check("redir_req_addr", IReq_addr, 32'h0000_0200);
    check("redir_bubble", 32'(FetchValid_IF), 32'd0);
    repeat (10) step(100, 100, 0, 0, 0);

    // Memory not ready: address stable, valid held, FIFO drains.
    for (int i = 0; i < 6; i++) begin
      step(0, 100, 0, 0, 0);
      check("notready_addr", IReq_addr, req_exp);
    end
    check("notready_req_valid", 32'(IReq_valid), 32'd1);
    check("notready_drained", 32'(FetchValid_IF), 32'd0);

    // Redirect with requests in flight, then reset while stale words are pending.
    repeat (3) step(100, 30, 0, 0, 0);
    step(100, 100, 0, 0, 100);
    step(100, 0, 0, 0, 0);
    do_reset(2);
    repeat (12) step(100, 100, 0, 0, 0);

    // Randomized mix with periodic resets.
    for (int k = 0; k < 4; k++) begin
      repeat (800) step(70, 60, 25, 15, 4);
      do_reset(2);
    end
    repeat (20) step(100, 100, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
